// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single level-handshake memory controller port.
// One transaction in flight; round-robin or fixed priority; optional ack watchdog.
module mem_arbiter #(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIXED_PRIO = 0,
  parameter int unsigned TIMEOUT    = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              r0_en,
  input  logic              r0_we,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_di,
  output logic [DATA_W-1:0] r0_do,
  output logic              r0_ack,
  input  logic              r1_en,
  input  logic              r1_we,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_di,
  output logic [DATA_W-1:0] r1_do,
  output logic              r1_ack,
  output logic              err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_di,
  input  logic [DATA_W-1:0] mem_do,
  input  logic              mem_do_ack
);

  localparam int unsigned WdogW = (TIMEOUT > 0) ? $clog2(TIMEOUT) + 1 : 1;
  localparam logic [WdogW-1:0] WdogLast = WdogW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e              state_q, state_d;
  logic                mem_en_q, mem_en_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_di_q, mem_di_d;
  logic                grant_q, grant_d;
  logic                last_grant_q, last_grant_d;
  logic [WdogW-1:0]    wdog_q, wdog_d;
  logic [DATA_W-1:0]   r0_do_q, r0_do_d, r1_do_q, r1_do_d;
  logic                r0_ack_q, r0_ack_d, r1_ack_q, r1_ack_d;
  logic                err_q, err_d;
  logic                win1;

  // On a tie, round-robin hands the grant to whichever port did not win last time.
  always_comb begin
    win1 = r1_en;
    if (r0_en && r1_en) begin
      win1 = (FIXED_PRIO != 0) ? 1'b0 : ~last_grant_q;
    end
  end

  always_comb begin
    state_d      = state_q;
    mem_en_d     = mem_en_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_di_d     = mem_di_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    wdog_d       = wdog_q;
    r0_do_d      = r0_do_q;
    r1_do_d      = r1_do_q;
    r0_ack_d     = r0_ack_q;
    r1_ack_d     = r1_ack_q;
    err_d        = err_q;
    unique case (state_q)
      StIdle: begin
        if (r0_en || r1_en) begin
          grant_d      = win1;
          last_grant_d = win1;
          mem_en_d     = 1'b1;
          mem_we_d     = win1 ? r1_we : r0_we;
          mem_addr_d   = win1 ? r1_addr : r0_addr;
          mem_di_d     = win1 ? r1_di : r0_di;
          wdog_d       = '0;
          state_d      = StBusy;
        end
      end
      StBusy: begin
        if (mem_do_ack) begin
          mem_en_d = 1'b0;
          if (grant_q) begin
            r1_do_d  = mem_do;
            r1_ack_d = 1'b1;
          end else begin
            r0_do_d  = mem_do;
            r0_ack_d = 1'b1;
          end
          state_d = StDone;
        end else if (TIMEOUT != 0) begin
          wdog_d = wdog_q + 1'b1;
          if (wdog_q == WdogLast) begin
            mem_en_d = 1'b0;
            err_d    = 1'b1;
            wdog_d   = wdog_q;
            if (grant_q) begin
              r1_do_d  = '0;
              r1_ack_d = 1'b1;
            end else begin
              r0_do_d  = '0;
              r0_ack_d = 1'b1;
            end
            state_d = StDone;
          end
        end
      end
      StDone: begin
        r0_ack_d = 1'b0;
        r1_ack_d = 1'b0;
        err_d    = 1'b0;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_di_q     <= '0;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      wdog_q       <= '0;
      r0_do_q      <= '0;
      r1_do_q      <= '0;
      r0_ack_q     <= 1'b0;
      r1_ack_q     <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_di_q     <= mem_di_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      wdog_q       <= wdog_d;
      r0_do_q      <= r0_do_d;
      r1_do_q      <= r1_do_d;
      r0_ack_q     <= r0_ack_d;
      r1_ack_q     <= r1_ack_d;
      err_q        <= err_d;
    end
  end

  assign mem_en   = mem_en_q;
  assign mem_we   = mem_we_q;
  assign mem_addr = mem_addr_q;
  assign mem_di   = mem_di_q;
  assign r0_do    = r0_do_q;
  assign r1_do    = r1_do_q;
  assign r0_ack   = r0_ack_q;
  assign r1_ack   = r1_ack_q;
  assign err      = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench: a round-robin/no-watchdog arbiter and a fixed-priority/TIMEOUT=4 arbiter
// driven by the same requester and memory stimulus.
module tb_mem_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       r0_en, r0_we, r1_en, r1_we, mem_do_ack;
  logic [7:0] r0_addr, r0_di, r1_addr, r1_di, mem_do;

  logic [7:0] rr_r0_do, rr_r1_do, rr_mem_addr, rr_mem_di;
  logic       rr_r0_ack, rr_r1_ack, rr_err, rr_mem_en, rr_mem_we;
  logic [7:0] fp_r0_do, fp_r1_do, fp_mem_addr, fp_mem_di;
  logic       fp_r0_ack, fp_r1_ack, fp_err, fp_mem_en, fp_mem_we;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(8), .DATA_W(8), .FIXED_PRIO(0), .TIMEOUT(0)) dut_rr (
    .clk(clk), .reset(rst_n),
    .r0_en(r0_en), .r0_we(r0_we), .r0_addr(r0_addr), .r0_di(r0_di),
    .r0_do(rr_r0_do), .r0_ack(rr_r0_ack),
    .r1_en(r1_en), .r1_we(r1_we), .r1_addr(r1_addr), .r1_di(r1_di),
    .r1_do(rr_r1_do), .r1_ack(rr_r1_ack),
    .err(rr_err), .mem_en(rr_mem_en), .mem_we(rr_mem_we), .mem_addr(rr_mem_addr),
    .mem_di(rr_mem_di), .mem_do(mem_do), .mem_do_ack(mem_do_ack)
  );

  mem_arbiter #(.ADDR_W(8), .DATA_W(8), .FIXED_PRIO(1), .TIMEOUT(4)) dut_fp (
    .clk(clk), .reset(rst_n),
    .r0_en(r0_en), .r0_we(r0_we), .r0_addr(r0_addr), .r0_di(r0_di),
    .r0_do(fp_r0_do), .r0_ack(fp_r0_ack),
    .r1_en(r1_en), .r1_we(r1_we), .r1_addr(r1_addr), .r1_di(r1_di),
    .r1_do(fp_r1_do), .r1_ack(fp_r1_ack),
    .err(fp_err), .mem_en(fp_mem_en), .mem_we(fp_mem_we), .mem_addr(fp_mem_addr),
    .mem_di(fp_mem_di), .mem_do(mem_do), .mem_do_ack(mem_do_ack)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    r0_en = 0; r0_we = 0; r0_addr = 0; r0_di = 0;
    r1_en = 0; r1_we = 0; r1_addr = 0; r1_di = 0;
    mem_do = 0; mem_do_ack = 0;
    #12;
    check("rst rr mem_en", {7'd0, rr_mem_en}, 8'd0);
    check("rst fp r0_do", fp_r0_do, 8'd0);
    check("rst rr err", {7'd0, rr_err}, 8'd0);
    rst_n = 1'b1;
    step();

    // r0 read at 0x10, memory acks three cycles after the grant with 0xA5.
    r0_en = 1; r0_we = 0; r0_addr = 8'h10;
    step();
    check("rd rr mem_en", {7'd0, rr_mem_en}, 8'd1);
    check("rd rr mem_addr", rr_mem_addr, 8'h10);
    check("rd fp mem_we", {7'd0, fp_mem_we}, 8'd0);
    step();
    step();
    check("rd no early ack", {7'd0, rr_r0_ack}, 8'd0);
    mem_do = 8'hA5; mem_do_ack = 1;
    step();
    check("rd rr r0_ack", {7'd0, rr_r0_ack}, 8'd1);
    check("rd rr r0_do", rr_r0_do, 8'hA5);
    check("rd fp r0_do", fp_r0_do, 8'hA5);
    check("rd rr mem_en drop", {7'd0, rr_mem_en}, 8'd0);
    check("rd rr r1_ack", {7'd0, rr_r1_ack}, 8'd0);
    check("rd fp err", {7'd0, fp_err}, 8'd0);
    r0_en = 0; mem_do_ack = 0;
    step();
    check("rd r0_ack pulse", {7'd0, rr_r0_ack}, 8'd0);
    check("rd r0_do hold", rr_r0_do, 8'hA5);

    // Reset asserted mid-BUSY clears outputs immediately.
    r1_en = 1; r1_we = 1; r1_addr = 8'h55; r1_di = 8'h77;
    step();
    check("rb rr mem_en busy", {7'd0, rr_mem_en}, 8'd1);
    r1_en = 0;
    rst_n = 1'b0;
    #1;
    check("rb rr mem_en", {7'd0, rr_mem_en}, 8'd0);
    check("rb fp mem_en", {7'd0, fp_mem_en}, 8'd0);
    check("rb rr r0_do", rr_r0_do, 8'd0);
    check("rb fp err", {7'd0, fp_err}, 8'd0);
    step();
    rst_n = 1'b1;
    step();
    check("rb idle rr mem_en", {7'd0, rr_mem_en}, 8'd0);
    check("rb idle fp mem_en", {7'd0, fp_mem_en}, 8'd0);

    // Both ports request continuously: rr alternates 0,1,0,1; fp always picks port 0.
    r0_en = 1; r0_we = 0; r0_addr = 8'h01;
    r1_en = 1; r1_we = 0; r1_addr = 8'h02;
    for (int i = 0; i < 4; i++) begin
      step();
      check("tie rr mem_addr", rr_mem_addr, (i % 2 == 0) ? 8'h01 : 8'h02);
      check("tie fp mem_addr", fp_mem_addr, 8'h01);
      mem_do = 8'h40 + 8'(i); mem_do_ack = 1;
      step();
      check("tie rr r0_ack", {7'd0, rr_r0_ack}, (i % 2 == 0) ? 8'd1 : 8'd0);
      check("tie rr r1_ack", {7'd0, rr_r1_ack}, (i % 2 == 0) ? 8'd0 : 8'd1);
      check("tie fp r0_ack", {7'd0, fp_r0_ack}, 8'd1);
      check("tie fp r1_ack", {7'd0, fp_r1_ack}, 8'd0);
      check("tie fp r0_do", fp_r0_do, 8'h40 + 8'(i));
      mem_do_ack = 0;
      step();
    end
    check("tie rr r0_do", rr_r0_do, 8'h42);
    check("tie rr r1_do", rr_r1_do, 8'h43);
    r0_en = 0; r1_en = 0;
    step();

    // r1 write; requester changes addr/data mid-BUSY, latched values must hold.
    r1_en = 1; r1_we = 1; r1_addr = 8'h20; r1_di = 8'h3C;
    step();
    check("wr rr mem_we", {7'd0, rr_mem_we}, 8'd1);
    check("wr rr mem_addr", rr_mem_addr, 8'h20);
    r1_addr = 8'h21; r1_di = 8'hFF; r1_we = 0;
    step();
    check("wr rr addr hold", rr_mem_addr, 8'h20);
    check("wr rr di hold", rr_mem_di, 8'h3C);
    check("wr fp addr hold", fp_mem_addr, 8'h20);
    check("wr fp we hold", {7'd0, fp_mem_we}, 8'd1);
    mem_do = 8'h99; mem_do_ack = 1;
    step();
    check("wr rr r1_ack", {7'd0, rr_r1_ack}, 8'd1);
    check("wr rr r1_do", rr_r1_do, 8'h99);
    check("wr rr r0_do kept", rr_r0_do, 8'h42);
    r1_en = 0; mem_do_ack = 0;
    step();

    // Memory never acks: fp (TIMEOUT=4) aborts four edges after grant; rr waits.
    r0_en = 1; r0_we = 0; r0_addr = 8'h30;
    step();
    step();
    step();
    step();
    check("wd fp still busy", {7'd0, fp_mem_en}, 8'd1);
    check("wd fp no ack yet", {7'd0, fp_r0_ack}, 8'd0);
    step();
    check("wd fp r0_ack", {7'd0, fp_r0_ack}, 8'd1);
    check("wd fp err", {7'd0, fp_err}, 8'd1);
    check("wd fp mem_en", {7'd0, fp_mem_en}, 8'd0);
    check("wd fp r0_do", fp_r0_do, 8'd0);
    check("wd rr no err", {7'd0, rr_err}, 8'd0);
    r0_en = 0;
    step();
    check("wd fp err pulse", {7'd0, fp_err}, 8'd0);
    check("wd rr still busy", {7'd0, rr_mem_en}, 8'd1);
    // fp is idle now and must ignore this ack; rr completes with it.
    mem_do = 8'h5A; mem_do_ack = 1;
    step();
    check("wd rr r0_ack", {7'd0, rr_r0_ack}, 8'd1);
    check("wd rr r0_do", rr_r0_do, 8'h5A);
    check("wd fp ignore ack", {7'd0, fp_r0_ack}, 8'd0);
    check("wd fp do kept", fp_r0_do, 8'd0);
    mem_do_ack = 0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
